// File: rtl/fx_pkg.sv
// fx_pkg: Q8.8 fixed-point constants, element/matrix types and identity helper.
package fx_pkg;
    localparam int FRAC_BITS = 8;
    localparam int DATA_W    = 16;
    localparam logic [DATA_W-1:0] FX_ONE = DATA_W'(1 << FRAC_BITS);

    typedef logic signed [DATA_W-1:0] fx_t;
    typedef logic [15:0][DATA_W-1:0] mat4_t;

    function automatic mat4_t mat_identity();
        mat4_t m;
        m = '0;
        m[0]  = FX_ONE;
        m[5]  = FX_ONE;
        m[10] = FX_ONE;
        m[15] = FX_ONE;
        return m;
    endfunction
endpackage

// File: rtl/fx_neg.sv
// fx_neg: combinational Q8.8 negate; VIEW_MATRIX_SAT_NEG_EN clamps -(-128.0) to +127.996.
import fx_pkg::*;

module fx_neg (
    input  fx_t i_v,
    output fx_t o_v
);
`ifdef VIEW_MATRIX_SAT_NEG_EN
    assign o_v = (i_v == 16'sh8000) ? 16'sh7FFF : ~i_v + 16'sd1;
`else
    assign o_v = ~i_v + 16'sd1;
`endif
endmodule

// File: rtl/view_matrix_gen.sv
// view_matrix_gen: registered 4x4 camera translation matrix in Q8.8.
// Optional macro VIEW_MATRIX_SAT_NEG_EN selects saturating negation in fx_neg.
import fx_pkg::*;

module view_matrix_gen (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                in_valid,
    input  logic [15:0]         x_pos,
    input  logic [15:0]         y_pos,
    input  logic [15:0]         z_pos,
    output logic [15:0][15:0]   view_matrix,
    output logic                out_valid
);
    fx_t w_nx, w_ny, w_nz;
    fx_t r_nx, r_ny, r_nz;
    logic r_valid;

    fx_neg u_neg_x (.i_v(fx_t'(x_pos)), .o_v(w_nx));
    fx_neg u_neg_y (.i_v(fx_t'(y_pos)), .o_v(w_ny));
    fx_neg u_neg_z (.i_v(fx_t'(z_pos)), .o_v(w_nz));

    // Only the translation column is stored; zeroed translation yields identity.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_nx    <= '0;
            r_ny    <= '0;
            r_nz    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_nx <= w_nx;
                r_ny <= w_ny;
                r_nz <= w_nz;
            end
        end
    end

    always_comb begin
        view_matrix     = mat_identity();
        view_matrix[3]  = r_nx;
        view_matrix[7]  = r_ny;
        view_matrix[11] = r_nz;
    end

    assign out_valid = r_valid;
endmodule

// File: tb/tb_view_matrix_gen.sv
// tb_view_matrix_gen: scoreboard bench with directed vectors for view_matrix_gen.
module tb_view_matrix_gen;
    logic               Clk = 1'b0;
    logic               Reset;
    logic               in_valid;
    logic [15:0]        x_pos, y_pos, z_pos;
    logic [15:0][15:0]  view_matrix;
    logic               out_valid;

    int total = 0;
    int bad   = 0;
    logic [15:0][15:0] q[$];
    logic [15:0][15:0] last_exp;

    view_matrix_gen dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid),
        .x_pos(x_pos), .y_pos(y_pos), .z_pos(z_pos),
        .view_matrix(view_matrix), .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0][15:0] mk(input logic [15:0] nx, ny, nz);
        logic [15:0][15:0] m;
        m = '0;
        m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
        m[3] = nx; m[7] = ny; m[11] = nz;
        return m;
    endfunction

    task automatic chk_mat(input string name, input logic [15:0][15:0] exp);
        total++;
        if (view_matrix !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, view_matrix, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Drive one capture at a negedge and record the hand-computed result.
    task automatic issue(input logic [15:0] x, y, z, nx, ny, nz);
        in_valid = 1'b1;
        x_pos = x; y_pos = y; z_pos = z;
        last_exp = mk(nx, ny, nz);
        q.push_back(last_exp);
        @(negedge Clk);
    endtask

    always @(posedge Clk) begin
        #1;
        if (out_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out_valid: got 1 want 0");
            end else begin
                logic [15:0][15:0] e;
                e = q.pop_front();
                if (view_matrix !== e) begin
                    bad++;
                    $display("FAIL scoreboard: got %h want %h", view_matrix, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] sat;
`ifdef VIEW_MATRIX_SAT_NEG_EN
        sat = 16'h7FFF;
`else
        sat = 16'h8000;
`endif
        Reset = 1'b1; in_valid = 1'b0;
        x_pos = 16'h1111; y_pos = 16'h2222; z_pos = 16'h3333;
        repeat (2) @(negedge Clk);
        chk_mat("reset_identity", mk(16'h0, 16'h0, 16'h0));
        chk_bit("reset_out_valid", out_valid, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        issue(16'h0234, 16'h0416, 16'h0396, 16'hFDCC, 16'hFBEA, 16'hFC6A);
        in_valid = 1'b0;
        x_pos = 16'h0555; y_pos = 16'h0666; z_pos = 16'h0777;
        repeat (2) @(negedge Clk);
        chk_mat("hold_matrix", last_exp);
        chk_bit("hold_out_valid", out_valid, 1'b0);

        issue(16'hFF00, 16'h0000, 16'h0080, 16'h0100, 16'h0000, 16'hFF80);
        in_valid = 1'b0;
        @(negedge Clk);

        // Back-to-back captures, including boundary values.
        issue(16'h7FFF, 16'h8000, 16'h0001, 16'h8001, sat, 16'hFFFF);
        chk_bit("b2b_out_valid_0", out_valid, 1'b1);
        issue(16'h8000, 16'h0100, 16'hFFFF, sat, 16'hFF00, 16'h0001);
        chk_bit("b2b_out_valid_1", out_valid, 1'b1);
        issue(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        in_valid = 1'b0;
        @(negedge Clk);
        chk_bit("b2b_end_out_valid", out_valid, 1'b0);

        issue(16'h0A00, 16'hF600, 16'h0001, 16'hF600, 16'h0A00, 16'hFFFF);
        in_valid = 1'b0;
        @(negedge Clk);

        Reset = 1'b1; in_valid = 1'b1;
        x_pos = 16'h1234; y_pos = 16'h5678; z_pos = 16'h0ABC;
        @(negedge Clk);
        chk_mat("reset_vs_valid_matrix", mk(16'h0, 16'h0, 16'h0));
        chk_bit("reset_vs_valid_out_valid", out_valid, 1'b0);
        Reset = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge Clk);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_outputs: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
